// File: rtl/restador_serial.sv
// restador_serial: bit-serial WIDTH-bit subtractor (a - b), LSB first.
// It uses one full-subtractor cell and a borrow flip-flop, with a start/done handshake.
// Optional feature macro: RESTADOR_OVF_EN. When it is defined, the signed overflow flag is registered.
// When it is undefined, ovf is tied to 0.
module restador_serial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CntW-1:0]  r_cnt;
  logic             r_bout;

  logic w_d;
  logic w_brw_n;
  logic w_last;
  logic w_load;
  logic w_shift;

  // Full-subtractor cell on the current LSBs
  assign w_d     = r_ra[0] ^ r_rb[0] ^ r_brw;
  assign w_brw_n = (~r_ra[0] & r_rb[0]) | (~(r_ra[0] ^ r_rb[0]) & r_brw);
  assign w_last  = (r_cnt == CntLast);

  assign diff = r_res;
  assign bout = r_bout;

  // Next-state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (init) begin
          w_load      = 1'b1;
          w_state_nxt = StShift;
        end
      end
      StShift: begin
        busy    = 1'b1;
        w_shift = 1'b1;
        if (w_last) w_state_nxt = StDone;
      end
      StDone: begin
        done        = 1'b1;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Operand shift registers, borrow, counter, result and final borrow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra   <= '0;
      r_rb   <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_bout <= 1'b0;
    end else if (w_load) begin
      r_ra  <= a;
      r_rb  <= b;
      r_brw <= 1'b0;
      r_cnt <= '0;
    end else if (w_shift) begin
      r_ra  <= {1'b0, r_ra[WIDTH-1:1]};
      r_rb  <= {1'b0, r_rb[WIDTH-1:1]};
      r_res <= {w_d, r_res[WIDTH-1:1]};
      r_brw <= w_brw_n;
      // Counter saturates at WIDTH-1; it is reloaded on the next start
      if (!w_last) r_cnt <= r_cnt + CntW'(1);
      if (w_last)  r_bout <= w_brw_n;
    end
  end

`ifdef RESTADOR_OVF_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // Capture the operand sign bits at load; the last cell output is the result MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_shift && w_last) begin
      r_ovf <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_restador_serial.sv
// Directed bench for restador_serial (WIDTH=4) with hand-computed expected values.
module tb_restador_serial;

`ifdef RESTADOR_OVF_EN
  localparam logic OvfEn = 1'b1;
`else
  localparam logic OvfEn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       init;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] diff;
  logic       bout;
  logic       ovf;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;

  restador_serial #(.WIDTH(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .init (init),
    .a    (a),
    .b    (b),
    .diff (diff),
    .bout (bout),
    .ovf  (ovf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present operands with init high; return #1 after the accepting edge (edge 0)
  task automatic launch(input logic [3:0] va, input logic [3:0] vb);
    @(negedge clk);
    a    = va;
    b    = vb;
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
  endtask

  // Watch n edges after acceptance; init is dropped after edge `hold` when hold > 0
  task automatic collect(input int n, input int hold, output int npulse, output int first,
                         output int last, output logic [3:0] d, output logic bo,
                         output logic ov, output logic busy2);
    npulse = 0;
    first  = -1;
    last   = -1;
    d      = '0;
    bo     = 1'b0;
    ov     = 1'b0;
    busy2  = 1'b0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (k == 2) busy2 = busy;
      if (done) begin
        npulse++;
        last = k;
        if (first < 0) begin
          first = k;
          d     = diff;
          bo    = bout;
          ov    = ovf;
        end
      end
      if (k == hold) init = 1'b0;
    end
  endtask

  // One full operation with result checks
  task automatic run_op(input string tag, input logic [3:0] va, input logic [3:0] vb,
                        input logic [3:0] ed, input logic eb, input logic eo);
    int np, fi, la;
    logic [3:0] d;
    logic bo, ov, b2;
    launch(va, vb);
    a = ~va;  // late operand changes must not matter
    b = ~vb;
    collect(8, 0, np, fi, la, d, bo, ov, b2);
    check_eq({tag, "_busy"}, 32'(b2), 32'd1);
    check_eq({tag, "_pulses"}, 32'(np), 32'd1);
    check_eq({tag, "_latency"}, 32'(fi), 32'd4);
    check_eq({tag, "_diff"}, 32'(d), 32'(ed));
    check_eq({tag, "_bout"}, 32'(bo), 32'(eb));
    check_eq({tag, "_ovf"}, 32'(ov), 32'(eo));
    check_eq({tag, "_hold_diff"}, 32'(diff), 32'(ed));
    check_eq({tag, "_hold_bout"}, 32'(bout), 32'(eb));
    check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int np, fi, la;
    logic [3:0] d;
    logic bo, ov, b2;

    rst_n = 1'b0;
    init  = 1'b0;
    a     = '0;
    b     = '0;
    #20;
    rst_n = 1'b1;
    #1;
    check_eq("rst_diff", 32'(diff), 32'd0);
    check_eq("rst_bout", 32'(bout), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);

    run_op("s5m3", 4'd5, 4'd3, 4'd2, 1'b0, 1'b0);
    run_op("s3m5", 4'd3, 4'd5, 4'd14, 1'b1, 1'b0);
    run_op("s8m1", 4'd8, 4'd1, 4'd7, 1'b0, OvfEn);
    run_op("s0m1", 4'd0, 4'd1, 4'd15, 1'b1, 1'b0);
    run_op("s7m8", 4'd7, 4'd8, 4'd15, 1'b1, OvfEn);

    // Second request during SHIFT is ignored, not queued
    launch(4'd15, 4'd15);
    a    = 4'd0;
    b    = 4'd1;
    init = 1'b1;
    collect(12, 2, np, fi, la, d, bo, ov, b2);
    check_eq("ign_pulses", 32'(np), 32'd1);
    check_eq("ign_latency", 32'(fi), 32'd4);
    check_eq("ign_diff", 32'(d), 32'd0);
    check_eq("ign_bout", 32'(bo), 32'd0);

    // init held high re-triggers every WIDTH+2 cycles
    launch(4'd7, 4'd2);
    init = 1'b1;
    collect(11, 0, np, fi, la, d, bo, ov, b2);
    init = 1'b0;
    check_eq("b2b_pulses", 32'(np), 32'd2);
    check_eq("b2b_first", 32'(fi), 32'd4);
    check_eq("b2b_second", 32'(la), 32'd10);
    check_eq("b2b_diff", 32'(d), 32'd5);
    repeat (8) @(posedge clk);

    // Reset during the 2nd shift cycle aborts the operation
    launch(4'd9, 4'd2);
    @(posedge clk);
    #1;
    check_eq("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_diff", 32'(diff), 32'd0);
    check_eq("abort_bout", 32'(bout), 32'd0);
    check_eq("abort_ovf", 32'(ovf), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    np = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if (done) np++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (done) np++;
    end
    check_eq("abort_no_done", 32'(np), 32'd0);
    run_op("s9m2", 4'd9, 4'd2, 4'd7, 1'b0, OvfEn);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time limit so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
